// File: rtl/sram_resp.sv
// sram_resp: word-organised on-chip RAM serving the CPU instruction and data
// SRAM-style master ports with one-cycle registered reads. The data port also
// decodes a small configuration window (LEDs, number display, timer, switches).
module sram_resp #(
    parameter int unsigned ADDR_W  = 12,
    parameter logic [15:0] CONF_HI = 16'hbfaf
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch,
    output logic [15:0] led,
    output logic [31:0] num_data
);

    localparam int unsigned Depth = 1 << ADDR_W;

    localparam logic [15:0] OffLed    = 16'hf000;
    localparam logic [15:0] OffNum    = 16'hf010;
    localparam logic [15:0] OffTimer  = 16'he000;
    localparam logic [15:0] OffSwitch = 16'hf020;

    logic [31:0] mem [Depth];

    logic [ADDR_W-1:0] inst_idx;
    logic [ADDR_W-1:0] data_idx;
    logic [15:0]       data_off;
    logic              data_win;
    logic              inst_we;
    logic              data_ram_we;
    logic              data_reg_we;
    logic [31:0]       inst_word;
    logic [31:0]       data_ram_word;
    logic [31:0]       reg_rdata;

    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic [15:0] led_q, led_d;
    logic [31:0] num_q, num_d;
    logic [31:0] timer_q, timer_d;

    // Address bits outside the RAM index are don't-care on the instruction port.
    logic unused_inst_addr;
    assign unused_inst_addr = ^{inst_sram_addr[31:ADDR_W+2], inst_sram_addr[1:0]};

    // Byte-enable merge of new data onto an existing word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wen);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

    // Address decode and read-first RAM lookups.
    always_comb begin
        inst_idx      = inst_sram_addr[ADDR_W+1:2];
        data_idx      = data_sram_addr[ADDR_W+1:2];
        data_off      = data_sram_addr[15:0];
        data_win      = (data_sram_addr[31:16] == CONF_HI);
        inst_we       = inst_sram_en && (inst_sram_wen != 4'b0000);
        data_ram_we   = data_sram_en && !data_win && (data_sram_wen != 4'b0000);
        data_reg_we   = data_sram_en && data_win && (data_sram_wen != 4'b0000);
        inst_word     = mem[inst_idx];
        data_ram_word = mem[data_idx];
    end

    // Config window read mux; unmapped offsets read zero.
    always_comb begin
        reg_rdata = 32'h0;
        case (data_off)
            OffLed:    reg_rdata = {16'h0, led_q};
            OffNum:    reg_rdata = num_q;
            OffTimer:  reg_rdata = timer_q;
            OffSwitch: reg_rdata = {24'h0, switch};
            default:   reg_rdata = 32'h0;
        endcase
    end

    // Next-state for read data and config registers.
    always_comb begin
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        led_d        = led_q;
        num_d        = num_q;
        timer_d      = timer_q + 32'd1;

        if (inst_sram_en) inst_rdata_d = inst_word;
        if (data_sram_en) data_rdata_d = data_win ? reg_rdata : data_ram_word;

        if (data_reg_we) begin
            case (data_off)
                OffLed: begin
                    if (data_sram_wen[0]) led_d[7:0]  = data_sram_wdata[7:0];
                    if (data_sram_wen[1]) led_d[15:8] = data_sram_wdata[15:8];
                end
                OffNum:   num_d   = merge_bytes(num_q, data_sram_wdata, data_sram_wen);
                OffTimer: timer_d = merge_bytes(timer_q, data_sram_wdata, data_sram_wen);
                default: ;
            endcase
        end
    end

    // RAM writes: instruction bytes first, data bytes last so the data port wins
    // per byte on a shared word. Writes are dropped while reset is asserted.
    always_ff @(posedge clk) begin
        if (resetn) begin
            for (int i = 0; i < 4; i++) begin
                if (inst_we && inst_sram_wen[i]) begin
                    mem[inst_idx][8*i +: 8] <= inst_sram_wdata[8*i +: 8];
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (data_ram_we && data_sram_wen[i]) begin
                    mem[data_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_rdata_q <= 32'h0;
            data_rdata_q <= 32'h0;
            led_q        <= 16'hffff;
            num_q        <= 32'h0;
            timer_q      <= 32'h0;
        end else begin
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            led_q        <= led_d;
            num_q        <= num_d;
            timer_q      <= timer_d;
        end
    end

    assign inst_sram_rdata = inst_rdata_q;
    assign data_sram_rdata = data_rdata_q;
    assign led             = led_q;
    assign num_data        = num_q;

endmodule

// File: tb/tb_sram_resp.sv
// Bench for sram_resp: a transaction-level model tracks RAM words, config
// registers and expected read data; a compare process checks every cycle.
module tb_sram_resp;

    logic        clk;
    logic        resetn;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic [7:0]  switch;
    logic [15:0] led;
    logic [31:0] num_data;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    sram_resp #(.ADDR_W(12), .CONF_HI(16'hbfaf)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_wen  (inst_sram_wen),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_en   (data_sram_en),
        .data_sram_wen  (data_sram_wen),
        .data_sram_addr (data_sram_addr),
        .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata),
        .switch         (switch),
        .led            (led),
        .num_data       (num_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    logic [31:0] m_ram [int];
    logic [31:0] m_inst_rd, m_data_rd, m_num, m_timer;
    logic [15:0] m_led;
    bit          m_inst_known, m_data_known;

    function automatic logic [31:0] bmerge(input logic [31:0] old_word,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  wen);
        logic [31:0] r;
        r = old_word;
        for (int i = 0; i < 4; i++) if (wen[i]) r[8*i +: 8] = wdata[8*i +: 8];
        return r;
    endfunction

    // Words never fully written stay unknown (RAM is not reset).
    task automatic ram_write(input int idx, input logic [31:0] wd, input logic [3:0] wen);
        if (m_ram.exists(idx)) m_ram[idx] = bmerge(m_ram[idx], wd, wen);
        else if (wen == 4'hf) m_ram[idx] = wd;
    endtask

    task automatic model_reset();
        m_inst_rd = 0; m_data_rd = 0; m_inst_known = 1; m_data_known = 1;
        m_led = 16'hffff; m_num = 0; m_timer = 0;
    endtask

    task automatic model_edge();
        int ii, di;
        bit win;
        logic [15:0] off;
        logic [31:0] t_next, tmp;
        ii  = int'(inst_sram_addr[13:2]);
        di  = int'(data_sram_addr[13:2]);
        win = (data_sram_addr[31:16] == 16'hbfaf);
        off = data_sram_addr[15:0];
        if (inst_sram_en) begin
            m_inst_known = m_ram.exists(ii);
            m_inst_rd    = m_inst_known ? m_ram[ii] : 32'h0;
        end
        if (data_sram_en) begin
            if (win) begin
                m_data_known = 1;
                if (off == 16'hf000)      m_data_rd = {16'h0, m_led};
                else if (off == 16'hf010) m_data_rd = m_num;
                else if (off == 16'he000) m_data_rd = m_timer;
                else if (off == 16'hf020) m_data_rd = {24'h0, switch};
                else                      m_data_rd = 0;
            end else begin
                m_data_known = m_ram.exists(di);
                m_data_rd    = m_data_known ? m_ram[di] : 32'h0;
            end
        end
        t_next = m_timer + 1;
        if (data_sram_en && win && data_sram_wen != 0) begin
            if (off == 16'hf000) begin
                tmp   = bmerge({16'h0, m_led}, data_sram_wdata, {2'b00, data_sram_wen[1:0]});
                m_led = tmp[15:0];
            end else if (off == 16'hf010) m_num = bmerge(m_num, data_sram_wdata, data_sram_wen);
            else if (off == 16'he000) t_next = bmerge(m_timer, data_sram_wdata, data_sram_wen);
        end
        if (inst_sram_en && inst_sram_wen != 0) ram_write(ii, inst_sram_wdata, inst_sram_wen);
        if (data_sram_en && !win && data_sram_wen != 0)
            ram_write(di, data_sram_wdata, data_sram_wen);
        m_timer = t_next;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) model_reset();
            else model_edge();
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (m_inst_known) chk("model inst_rdata", inst_sram_rdata, m_inst_rd);
                if (m_data_known) chk("model data_rdata", data_sram_rdata, m_data_rd);
                chk("model led", {16'h0, led}, {16'h0, m_led});
                chk("model num_data", num_data, m_num);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic ie, input logic [3:0] iw, input logic [31:0] ia,
                        input logic [31:0] id, input logic de, input logic [3:0] dw,
                        input logic [31:0] da, input logic [31:0] dd);
        inst_sram_en = ie; inst_sram_wen = iw; inst_sram_addr = ia; inst_sram_wdata = id;
        data_sram_en = de; data_sram_wen = dw; data_sram_addr = da; data_sram_wdata = dd;
        @(negedge clk);
        inst_sram_en = 0; data_sram_en = 0;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic dwrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        step(0, 0, 0, 0, 1, w, a, d);
    endtask
    task automatic dread(input logic [31:0] a);
        step(0, 0, 0, 0, 1, 4'h0, a, 0);
    endtask
    task automatic iread(input logic [31:0] a);
        step(1, 4'h0, a, 0, 0, 0, 0, 0);
    endtask

    initial begin
        resetn = 0; switch = 0;
        inst_sram_en = 0; inst_sram_wen = 0; inst_sram_addr = 0; inst_sram_wdata = 0;
        data_sram_en = 0; data_sram_wen = 0; data_sram_addr = 0; data_sram_wdata = 0;
        @(negedge clk);
        chk_en = 1;
        // Reset held with random activity on every input.
        for (int i = 0; i < 4; i++) begin
            inst_sram_en = 1'($urandom); inst_sram_wen = 4'($urandom);
            inst_sram_addr = {$urandom_range(0, 15), 2'b00}; inst_sram_wdata = $urandom;
            data_sram_en = 1'($urandom); data_sram_wen = 4'($urandom);
            data_sram_addr = {$urandom_range(0, 15), 2'b00}; data_sram_wdata = $urandom;
            switch = 8'($urandom);
            @(negedge clk);
        end
        chk("reset inst_rdata", inst_sram_rdata, 32'h0);
        chk("reset data_rdata", data_sram_rdata, 32'h0);
        chk("reset led", {16'h0, led}, 32'h0000ffff);
        chk("reset num_data", num_data, 32'h0);
        inst_sram_en = 0; data_sram_en = 0; switch = 0;
        resetn = 1;
        idle(); idle();
        dread(32'hbfaf_e000);
        chk("timer after release", data_sram_rdata, 32'h2);

        // Known contents for words used below.
        dwrite(32'h20, 32'h0, 4'hf);
        dwrite(32'h10, 32'h0, 4'hf);

        // RAM byte write.
        dwrite(32'h10, 32'h1122_3344, 4'b1111);
        dwrite(32'h10, 32'hAABB_CCDD, 4'b0010);
        dread(32'h10);
        chk("ram byte write", data_sram_rdata, 32'h1122_CC44);
        idle();
        chk("rdata hold", data_sram_rdata, 32'h1122_CC44);

        // Cross-port read-first, then dual-port same-word write.
        step(1, 4'h0, 32'h20, 0, 1, 4'hf, 32'h20, 32'hDEAD_BEEF);
        chk("inst read-first", inst_sram_rdata, 32'h0);
        iread(32'h20);
        chk("inst after data write", inst_sram_rdata, 32'hDEAD_BEEF);
        step(1, 4'hf, 32'h30, 32'h1111_1111, 1, 4'b0011, 32'h30, 32'h2222_2222);
        iread(32'h31);
        chk("dual write data wins", inst_sram_rdata, 32'h1111_2222);
        step(1, 4'b1000, 32'h30, 32'h9900_0000, 0, 0, 0, 0);
        dread(32'h30);
        chk("inst byte write", data_sram_rdata, 32'h9911_2222);

        // Config window.
        dwrite(32'hbfaf_f000, 32'h12, 4'b0001);
        chk("led byte write", {16'h0, led}, 32'h0000ff12);
        dread(32'hbfaf_f000);
        chk("led readback", data_sram_rdata, 32'h0000ff12);
        dwrite(32'hbfaf_f000, 32'hAAAA_5555, 4'b1111);
        chk("led upper ignored", {16'h0, led}, 32'h0000_5555);
        dwrite(32'hbfaf_f010, 32'hCAFE_F00D, 4'hf);
        chk("num_data write", num_data, 32'hCAFE_F00D);
        switch = 8'h5a;
        dread(32'hbfaf_f020);
        chk("switch read", data_sram_rdata, 32'h0000_005A);
        dread(32'hbfaf_f004);
        chk("unmapped read", data_sram_rdata, 32'h0);

        // Timer write and wrap.
        dwrite(32'hbfaf_e000, 32'hffff_fffe, 4'hf);
        dread(32'hbfaf_e000);
        chk("timer N+1", data_sram_rdata, 32'hffff_fffe);
        dread(32'hbfaf_e000);
        chk("timer N+2", data_sram_rdata, 32'hffff_ffff);
        dread(32'hbfaf_e000);
        chk("timer wrap", data_sram_rdata, 32'h0);
        dread(32'hbfaf_e000);
        chk("timer after wrap", data_sram_rdata, 32'h1);

        // Window aliasing.
        dwrite(32'hbfaf_0010, 32'h9999_9999, 4'hf);
        iread(32'hbfaf_0010);
        chk("inst ignores window", inst_sram_rdata, 32'h1122_CC44);
        dread(32'h10);
        chk("window no ram write", data_sram_rdata, 32'h1122_CC44);

        // Reset asserted mid-access discards the write.
        data_sram_en = 1; data_sram_wen = 4'hf; data_sram_addr = 32'h10;
        data_sram_wdata = 32'h0;
        #2 resetn = 0;
        #1;
        chk("async reset led", {16'h0, led}, 32'h0000ffff);
        chk("async reset data_rdata", data_sram_rdata, 32'h0);
        @(negedge clk);
        data_sram_en = 0;
        resetn = 1;
        iread(32'h10);
        chk("write dropped in reset", inst_sram_rdata, 32'h1122_CC44);

        idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
